// File: rtl/fifo_state_reg.sv
// FIFO control stage: holds state/head/tail/count and turns wr_en/rd_en into the next state. State and strobes settle one edge after a request.
// No backpressure: requests are never stalled. Overflow and underflow show up as wr_err/rd_err and bump saturating counters.
module fifo_state_reg #(
  parameter int ADDR_W    = 3,
  parameter int CNT_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 err_clr,
  input  logic [ADDR_W-1:0]    next_head,
  input  logic [ADDR_W-1:0]    next_tail,
  input  logic [CNT_W-1:0]     next_data_count,
  output logic [2:0]           state,
  output logic [ADDR_W-1:0]    head,
  output logic [ADDR_W-1:0]    tail,
  output logic [CNT_W-1:0]     data_count,
  output logic                 full,
  output logic                 empty,
  output logic                 wr_ack,
  output logic                 wr_err,
  output logic                 rd_ack,
  output logic                 rd_err,
  output logic [ERR_CNT_W-1:0] wr_err_cnt,
  output logic [ERR_CNT_W-1:0] rd_err_cnt
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } fifo_state_t;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       legal_state;

  assign legal_state = (state_q == INIT)  || (state_q == NO_OP)    ||
                       (state_q == WRITE) || (state_q == WR_ERROR) ||
                       (state_q == READ)  || (state_q == RD_ERROR);

  // Decide on the occupancy after the in-flight operation, so back-to-back
  // requests see the count they will actually act on. Counts above DEPTH
  // fall naturally into "full" for writes and "non-empty" for reads.
  always_comb begin
    state_d = NO_OP;
    if (!legal_state) begin
      state_d = INIT;
    end else if (wr_en && !rd_en) begin
      state_d = (next_data_count < DEPTH) ? WRITE : WR_ERROR;
    end else if (rd_en && !wr_en) begin
      state_d = (next_data_count != '0) ? READ : RD_ERROR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ack  <= (state_d == WRITE);
      wr_err  <= (state_d == WR_ERROR);
      rd_ack  <= (state_d == READ);
      rd_err  <= (state_d == RD_ERROR);
    end
  end

  assign state = state_q;

  // Pointers are owned by the calculator; this stage only times them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      head       <= next_head;
      tail       <= next_tail;
      data_count <= next_data_count;
    end
  end

  assign full  = (data_count == DEPTH);
  assign empty = (data_count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else if (err_clr) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else begin
      if ((state_q == WR_ERROR) && (wr_err_cnt != '1)) begin
        wr_err_cnt <= wr_err_cnt + 1'b1;
      end
      if ((state_q == RD_ERROR) && (rd_err_cnt != '1)) begin
        rd_err_cnt <= rd_err_cnt + 1'b1;
      end
    end
  end

  strobe_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({wr_ack, wr_err, rd_ack, rd_err}));

endmodule

// File: tb/tb_fifo_state_reg.sv
// Directed bench for fifo_state_reg with a calculator stand-in and an occupancy-level reference model.
module tb_fifo_state_reg;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic       err_clr;
  logic [2:0] next_head;
  logic [2:0] next_tail;
  logic [3:0] next_data_count;
  logic [2:0] state;
  logic [2:0] head;
  logic [2:0] tail;
  logic [3:0] data_count;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;
  logic [7:0] wr_err_cnt;
  logic [7:0] rd_err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  fifo_state_reg #(.ADDR_W(3), .CNT_W(4), .ERR_CNT_W(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .err_clr         (err_clr),
    .next_head       (next_head),
    .next_tail       (next_tail),
    .next_data_count (next_data_count),
    .state           (state),
    .head            (head),
    .tail            (tail),
    .data_count      (data_count),
    .full            (full),
    .empty           (empty),
    .wr_ack          (wr_ack),
    .wr_err          (wr_err),
    .rd_ack          (rd_ack),
    .rd_err          (rd_err),
    .wr_err_cnt      (wr_err_cnt),
    .rd_err_cnt      (rd_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pointer calculator stand-in, closing the loop around the DUT.
  always_comb begin
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    if (state == 3'b010) begin
      next_data_count = data_count + 4'd1;
      next_tail       = tail + 3'd1;
    end else if (state == 3'b100) begin
      next_data_count = data_count - 4'd1;
      next_head       = head + 3'd1;
    end
  end

  // Reference model: occupancy plus the operation that is currently under way.
  localparam int S_INIT = 0, S_NOP = 1, S_WR = 2, S_WERR = 3, S_RD = 4, S_RERR = 5;
  int m_state = S_INIT;
  int m_head  = 0;
  int m_tail  = 0;
  int m_cnt   = 0;
  int m_werr  = 0;
  int m_rerr  = 0;
  int m_occ;

  always_comb m_occ = m_cnt + ((m_state == S_WR) ? 1 : 0) - ((m_state == S_RD) ? 1 : 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= S_INIT;
      m_head  <= 0;
      m_tail  <= 0;
      m_cnt   <= 0;
      m_werr  <= 0;
      m_rerr  <= 0;
    end else begin
      m_cnt  <= m_occ;
      m_head <= (m_state == S_RD) ? (m_head + 1) % 8 : m_head;
      m_tail <= (m_state == S_WR) ? (m_tail + 1) % 8 : m_tail;
      if (wr_en && !rd_en)      m_state <= (m_occ < 8) ? S_WR : S_WERR;
      else if (rd_en && !wr_en) m_state <= (m_occ != 0) ? S_RD : S_RERR;
      else                      m_state <= S_NOP;
      m_werr <= err_clr ? 0 : ((m_state == S_WERR && m_werr < 255) ? m_werr + 1 : m_werr);
      m_rerr <= err_clr ? 0 : ((m_state == S_RERR && m_rerr < 255) ? m_rerr + 1 : m_rerr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("head", int'(head), m_head);
      check("tail", int'(tail), m_tail);
      check("data_count", int'(data_count), m_cnt);
      check("flags{full,empty,wa,we,ra,re}", int'({full, empty, wr_ack, wr_err, rd_ack, rd_err}),
            int'({m_cnt == 8, m_cnt == 0, m_state == S_WR, m_state == S_WERR,
                  m_state == S_RD, m_state == S_RERR}));
      check("wr_err_cnt", int'(wr_err_cnt), m_werr);
      check("rd_err_cnt", int'(rd_err_cnt), m_rerr);
    end
  end

  task automatic step(input logic w, input logic r, input logic c);
    wr_en   = w;
    rd_en   = r;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask

  int acks;

  initial begin
    reset_n = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst state", int'(state), 0);
    check("rst head", int'(head), 0);
    check("rst tail", int'(tail), 0);
    check("rst data_count", int'(data_count), 0);
    check("rst empty", int'(empty), 1);
    check("rst full", int'(full), 0);
    check("rst wr_err_cnt", int'(wr_err_cnt), 0);
    check("rst rd_err_cnt", int'(rd_err_cnt), 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Fill from empty: eight accepted writes, the ninth overflows.
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (wr_ack) acks++;
    end
    check("fill ack pulses", acks, 8);
    step(1'b1, 1'b0, 1'b0);
    check("overflow state", int'(state), 3);
    check("overflow wr_err", int'(wr_err), 1);
    check("overflow data_count", int'(data_count), 8);
    check("overflow full", int'(full), 1);
    check("overflow tail wrap", int'(tail), 0);
    step(1'b1, 1'b0, 1'b0);
    check("first wr_err_cnt", int'(wr_err_cnt), 1);

    // Saturation, then clear while still in WR_ERROR.
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
    check("wr_err_cnt saturated", int'(wr_err_cnt), 255);
    step(1'b1, 1'b0, 1'b1);
    check("clear beats increment", int'(wr_err_cnt), 0);
    check("clear keeps WR_ERROR", int'(state), 3);
    step(1'b0, 1'b0, 1'b0);

    // Drain, then underflow on empty.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("drained data_count", int'(data_count), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("underflow state", int'(state), 5);
    end
    step(1'b0, 1'b0, 1'b0);
    check("rd_err_cnt", int'(rd_err_cnt), 3);
    check("underflow head", int'(head), 0);
    check("underflow data_count", int'(data_count), 0);

    // Simultaneous requests at occupancy 4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("simul state", int'(state), 1);
      check("simul data_count", int'(data_count), 4);
      check("simul strobes", int'({wr_ack, wr_err, rd_ack, rd_err}), 0);
    end

    // Reset in the middle of a write at occupancy 5.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pre-reset data_count", int'(data_count), 5);
    check("pre-reset state", int'(state), 2);
    reset_n = 1'b0;
    #1;
    check("async rst state", int'(state), 0);
    check("async rst data_count", int'(data_count), 0);
    check("async rst empty", int'(empty), 1);
    #1 reset_n = 1'b1;
    wr_en = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("post-reset WRITE", int'(state), 2);
    check("post-reset count before", int'(data_count), 0);
    step(1'b0, 1'b0, 1'b0);
    check("post-reset count after", int'(data_count), 1);

    step(1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_state_reg.md
Name: fifo_state_reg

Overview:
- Sequential control stage of the 8-entry FIFO.
- Holds the FIFO state register and the head/tail/data_count registers.
- Its registered outputs feed the combinational pointer calculator. That calculator's next_head/next_tail/next_data_count come back as inputs and are captured each clock.
- Decodes wr_en/rd_en into the next FIFO state, drives status flags and handshake strobes, and keeps saturating error counters.

Parameters:
ADDR_W, 3, head/tail pointer width (depth = 2**ADDR_W = 8)
CNT_W, 4, data_count width (ADDR_W+1)
ERR_CNT_W, 8, width of each saturating error counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
rd_en  in  1  read request
err_clr  in  1  synchronous clear of both error counters
next_head  in  ADDR_W  head value for next cycle, from pointer calculator
next_tail  in  ADDR_W  tail value for next cycle, from pointer calculator
next_data_count  in  CNT_W  count value for next cycle, from pointer calculator
state  out  3  current FIFO state
head  out  ADDR_W  registered head pointer
tail  out  ADDR_W  registered tail pointer
data_count  out  CNT_W  registered occupancy, 0..8
full  out  1  data_count == 8
empty  out  1  data_count == 0
wr_ack  out  1  state == WRITE
wr_err  out  1  state == WR_ERROR
rd_ack  out  1  state == READ
rd_err  out  1  state == RD_ERROR
wr_err_cnt  out  ERR_CNT_W  cycles spent in WR_ERROR, saturating
rd_err_cnt  out  ERR_CNT_W  cycles spent in RD_ERROR, saturating

Behaviour:
- State encoding (fixed, shared with calculator):
  - INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101.
  - 110/111 are illegal.
- Reset:
  - reset_n=0 asynchronously forces state=INIT; head, tail, data_count and both error counters go to 0.
  - Outputs take these values without a clock edge: full=0, empty=1, all strobes 0.
  - Reset asserted mid-operation discards the in-flight operation.
- Pointer registers:
  - Every rising edge, head<=next_head, tail<=next_tail, data_count<=next_data_count.
  - No local arithmetic on the pointers.
- Next-state decision uses next_data_count (occupancy after the current state's operation), not data_count. This keeps back-to-back requests exact.
  - wr_en=1, rd_en=0: WRITE if next_data_count < 8, else WR_ERROR.
  - rd_en=1, wr_en=0: READ if next_data_count != 0, else RD_ERROR.
  - Both 1 or both 0: NO_OP. A simultaneous request performs no operation and is not an error.
  - From INIT the same rules apply; INIT is only re-entered by reset.
  - From an illegal state, next state is INIT regardless of inputs.
  - next_data_count > 8 (calculator fault) is treated as full for writes and non-empty for reads.
- Latency:
  - A request sampled at edge k makes state=WRITE/READ during cycle k..k+1.
  - The matching pointer/count update lands at edge k+1.
  - wr_ack/rd_ack/wr_err/rd_err are decoded from the state register and are glitch-free.
- full/empty are combinational from the data_count register.
- Error counters:
  - At each edge where state==WR_ERROR (RD_ERROR), wr_err_cnt (rd_err_cnt) increments by 1.
  - Each counter saturates at 2**ERR_CNT_W-1 and does not wrap.
  - err_clr=1 at an edge zeroes both counters. Clear wins over a simultaneous increment.
- Pointer wrap (7->0) is produced by the calculator; this block passes it through unchanged.

Test Plan:
The bench models the calculator (WRITE: count+1, tail+1; READ: count-1, head+1; else hold).
- Reset: reset_n=0 with no clock -> state=000, head=tail=0, data_count=0, empty=1, full=0, wr_err_cnt=rd_err_cnt=0.
- Fill: 8 consecutive cycles wr_en=1 from empty -> 8 wr_ack pulses, data_count=8, full=1, tail wraps to 0. 9th wr_en -> state=011, wr_err=1, wr_err_cnt=1, data_count stays 8.
- Underflow: rd_en=1 for 3 cycles on empty -> state=101 each cycle, rd_err_cnt=3, head=0, data_count=0.
- Simultaneous: data_count=4, wr_en=rd_en=1 for 2 cycles -> state=001, data_count=4, no ack/err strobes.
- Saturation/clear: hold wr_en=1 at full for 300 cycles -> wr_err_cnt=255. Then err_clr=1 while still in WR_ERROR -> wr_err_cnt=0 after that edge.
- Mid-operation reset: drop reset_n during WRITE at data_count=5 -> immediately state=000, data_count=0. After release, wr_en=1 -> WRITE with data_count 0->1.
